// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed active-low 7-seg bus back to per-digit BCD; capture lands STABLE_CYCLES+1 cycles after inputs settle.
// Passive observer: no backpressure, inputs are sampled every cycle and outputs are registered.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  err,
    output logic [2:0]            err_digit,
    output logic                  frame_done
);

    localparam int SW = 7 + DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

    typedef enum logic {WAIT, HELD} state_t;

    state_t              state;
    logic [SW-1:0]       s1, s2, s2_d;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   mask;
    logic [DIGITS-1:0]   sel;
    logic [6:0]          pat;
    logic                diff;
    logic                sel_onehot;
    logic                capture;
    logic [2:0]          sel_idx;
    logic [4:0]          dec;

    // {legal, code}; anything outside the table decodes to E and is flagged illegal
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b1111111: decode = 5'h1F;
            default:    decode = 5'h0E;
        endcase
    endfunction

    assign sel        = s2[SW-1:7];
    assign pat        = s2[6:0];
    assign diff       = (s2 != s2_d);
    assign sel_onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    assign dec        = decode(pat);
    // Fire on the edge where cnt reaches STABLE_CYCLES-1 so the capture registers in that same cycle
    assign capture    = (state == WAIT) && !diff && (cnt == CNT_ARM) && sel_onehot;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) sel_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT;
            s1          <= '0;
            s2          <= '0;
            s2_d        <= '0;
            cnt         <= '0;
            mask        <= '0;
            bcd_out     <= '1;
            digit_valid <= '0;
            err         <= 1'b0;
            err_digit   <= '0;
            frame_done  <= 1'b0;
        end else begin
            s1         <= {dig_sel, seg};
            s2         <= s1;
            s2_d       <= s2;
            cnt        <= diff ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + CW'(1));
            frame_done <= 1'b0;

            case (state)
                WAIT: if (capture) state <= HELD;
                HELD: if (diff)    state <= WAIT;
                default:           state <= WAIT;
            endcase

            if (err_clr) err <= 1'b0;

            if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        bcd_out[4*i +: 4] <= dec[3:0];
                        digit_valid[i]    <= dec[4];
                    end
                end
                if (!dec[4]) begin
                    err       <= 1'b1;
                    err_digit <= sel_idx;
                end
                if (&(mask | sel)) begin
                    frame_done <= 1'b1;
                    mask       <= '0;
                end else begin
                    mask <= mask | sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: default build plus an 8-digit, 2-cycle-stability build.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [6:0]  seg = '0;
    logic [3:0]  dig_sel = '0;
    logic        err_clr = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        err;
    logic [2:0]  err_digit;
    logic        frame_done;

    logic [6:0]  seg8 = '0;
    logic [7:0]  dig_sel8 = '0;
    logic        err_clr8 = 1'b0;
    logic [31:0] bcd8;
    logic [7:0]  valid8;
    logic        err8;
    logic [2:0]  err_digit8;
    logic        fd8;

    int n_cmp  = 0;
    int n_fail = 0;
    int fd_cnt  = 0;
    int fd8_cnt = 0;

    logic [31:0] exp_q[$];
    logic [6:0]  seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [15:0] exp_bcd;
    logic [31:0] exp_bcd8;
    logic [3:0]  scan_val [0:3] = '{4'h1, 4'h9, 4'h6, 4'hF};

    seg7_scan_decoder u_dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel), .err_clr(err_clr),
        .bcd_out(bcd_out), .digit_valid(digit_valid), .err(err), .err_digit(err_digit),
        .frame_done(frame_done)
    );

    seg7_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .seg(seg8), .dig_sel(dig_sel8), .err_clr(err_clr8),
        .bcd_out(bcd8), .digit_valid(valid8), .err(err8), .err_digit(err_digit8),
        .frame_done(fd8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt  <= fd_cnt + 1;
        if (fd8 === 1'b1)        fd8_cnt <= fd8_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    initial begin
        // Reset values
        tick(3);
        push(32'hFFFF); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        check("rst_bcd", 32'(bcd_out));
        check("rst_valid", 32'(digit_valid));
        check("rst_err", 32'(err));
        check("rst_err_digit", 32'(err_digit));
        check("rst_frame_done", 32'(frame_done));
        rst_n = 1'b1;
        tick(1);

        // Single digit: capture first visible after E0+5 and not before
        dig_sel = 4'b0001; seg = seg_tab[2];
        push(32'hFFFF); push(32'hFFF2); push(32'h1); push(32'h0); push(32'hFFF2);
        tick(5);
        check("d0_before_capture", 32'(bcd_out));
        tick(1);
        check("d0_bcd", 32'(bcd_out));
        check("d0_valid", 32'(digit_valid));
        check("d0_frame_done", 32'(frame_done));
        tick(4);
        check("d0_held", 32'(bcd_out));

        // Full scan: 1, 9, 6, blank
        exp_bcd = 16'hFFF2;
        for (int k = 0; k < 4; k++) begin
            dig_sel = 4'(1) << k;
            seg     = (k == 3) ? 7'h7F : seg_tab[scan_val[k]];
            exp_bcd[4*k +: 4] = scan_val[k];
            push(32'(exp_bcd)); push((k == 3) ? 32'h1 : 32'h0); push(32'h0);
            tick(6);
            check("scan_bcd", 32'(bcd_out));
            check("scan_fd_at_capture", 32'(frame_done));
            tick(1);
            check("scan_fd_after", 32'(frame_done));
            tick(1);
        end
        push(32'hF);
        check("scan_valid", 32'(digit_valid));

        // Illegal pattern on digit 2
        dig_sel = 4'b0100; seg = 7'b0000001;
        push(32'hFE91); push(32'b1011); push(32'h1); push(32'h2);
        tick(6);
        check("ill_bcd", 32'(bcd_out));
        check("ill_valid", 32'(digit_valid));
        check("ill_err", 32'(err));
        check("ill_err_digit", 32'(err_digit));

        // Second illegal capture coincident with err_clr: set wins
        dig_sel = 4'b0010; seg = 7'b0000011;
        push(32'hFEE1); push(32'b1001); push(32'h1); push(32'h1);
        tick(5);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ill2_bcd", 32'(bcd_out));
        check("ill2_valid", 32'(digit_valid));
        check("ill2_err_set_wins", 32'(err));
        check("ill2_err_digit", 32'(err_digit));
        tick(2);
        push(32'h0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_clr_alone", 32'(err));

        // Glitching digit 1 between 3 and 8 never captures
        push(32'hFEE1);
        for (int t = 0; t < 8; t++) begin
            dig_sel = 4'b0010;
            seg     = t[0] ? seg_tab[8] : seg_tab[3];
            tick(2);
        end
        // Multi-hot select held long never captures
        dig_sel = 4'b0110; seg = seg_tab[5];
        tick(1);
        check("glitch_no_capture", 32'(bcd_out));
        push(32'hFEE1); push(32'b1001);
        tick(10);
        check("multihot_bcd", 32'(bcd_out));
        check("multihot_valid", 32'(digit_valid));

        // Reset asserted before capture completes
        dig_sel = 4'b0001; seg = seg_tab[3];
        tick(3);
        rst_n = 1'b0;
        #1;
        push(32'hFFFF); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        check("midrst_bcd", 32'(bcd_out));
        check("midrst_valid", 32'(digit_valid));
        check("midrst_err", 32'(err));
        check("midrst_err_digit", 32'(err_digit));
        check("midrst_frame_done", 32'(frame_done));
        tick(2);
        rst_n = 1'b1;
        push(32'hFFFF); push(32'hFFF3); push(32'h1);
        tick(5);
        check("postrst_before_capture", 32'(bcd_out));
        tick(1);
        check("postrst_bcd", 32'(bcd_out));
        check("postrst_valid", 32'(digit_valid));

        // 8-digit build, 3-cycle dwell, two full scans
        exp_bcd8 = '1;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                dig_sel8 = 8'(1) << i;
                seg8     = seg_tab[(s == 0) ? i : 9 - i];
                exp_bcd8[4*i +: 4] = 4'((s == 0) ? i : 9 - i);
                tick(3);
            end
            push(exp_bcd8); push(32'hFF); push(32'(s + 1)); push(32'h0);
            tick(4);
            check("d8_bcd", bcd8);
            check("d8_valid", 32'(valid8));
            check("d8_frame_count", 32'(fd8_cnt));
            check("d8_err", 32'(err8));
        end

        push(32'h1);
        check("d4_frame_count", 32'(fd_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
